// File: rtl/j1b_core.sv
// j1b_core: J1-encoding Forth stack CPU with separate Wishbone instruction and data buses
module j1b_core #(
  parameter int          DSTACK_DEPTH = 16,
  parameter int          RSTACK_DEPTH = 16,
  parameter logic [15:1] RESET_VECTOR = 15'h0000
) (
  input  logic        sys_clk_i,
  input  logic        sys_res_i,
  output logic [15:1] ins_adr_o,
  input  logic [15:0] ins_dat_i,
  output logic        ins_cyc_o,
  output logic        ins_stb_o,
  input  logic        ins_ack_i,
  output logic [15:1] dat_adr_o,
  output logic [15:0] dat_dat_o,
  input  logic [15:0] dat_dat_i,
  output logic        dat_we_o,
  output logic        dat_cyc_o,
  output logic        dat_stb_o,
  input  logic        dat_ack_i
);
  localparam int DW = $clog2(DSTACK_DEPTH);
  localparam int RW = $clog2(RSTACK_DEPTH);
  typedef enum logic [1:0] {BOOT, FETCH, EXEC, MEM} state_t;
  state_t        state;
  logic [15:1]   pc, pc_n, pc_inc, target;
  logic [15:0]   ir, t, t_n, n, r, alu, r_wd;
  logic [DW-1:0] dsp, dsp_n;
  logic [RW-1:0] rsp, rsp_n;
  logic [15:0]   dstack [DSTACK_DEPTH];
  logic [15:0]   rstack [RSTACK_DEPTH];
  logic [3:0]    op;
  logic          is_alu, is_mem, commit, d_we, r_we;
  logic          unused;
  assign n         = dstack[dsp];
  assign r         = rstack[rsp];
  assign op        = ir[11:8];
  assign pc_inc    = pc + 15'd1;
  assign target    = {2'b00, ir[12:0]};
  assign is_alu    = ir[15:13] == 3'b011;
  assign is_mem    = is_alu && (op == 4'd12 || ir[5]);
  assign commit    = (state == EXEC && !is_mem) || (state == MEM && dat_ack_i);
  assign unused    = ir[4];
  assign ins_adr_o = pc;
  assign ins_cyc_o = state == FETCH;
  assign ins_stb_o = state == FETCH;
  assign dat_adr_o = t[15:1];
  assign dat_dat_o = n;
  assign dat_cyc_o = state == MEM;
  assign dat_stb_o = state == MEM;
  assign dat_we_o  = state == MEM && ir[5];
  // ALU result from pre-instruction T, N, R; loads take the bus data, stores write N through
  always_comb begin
    alu = t;
    case (op)
      4'd1:    alu = n;
      4'd2:    alu = t + n;
      4'd3:    alu = t & n;
      4'd4:    alu = t | n;
      4'd5:    alu = t ^ n;
      4'd6:    alu = ~t;
      4'd7:    alu = {16{n == t}};
      4'd8:    alu = {16{$signed(n) < $signed(t)}};
      4'd9:    alu = n >> t[3:0];
      4'd10:   alu = t - 16'd1;
      4'd11:   alu = r;
      4'd12:   alu = ir[5] ? n : dat_dat_i;
      4'd13:   alu = n << t[3:0];
      4'd14:   alu = 16'(dsp);
      4'd15:   alu = {16{n < t}};
      default: alu = t;
    endcase
  end
  // next architectural state for the instruction held in IR
  always_comb begin
    t_n   = t;
    pc_n  = pc_inc;
    dsp_n = dsp;
    rsp_n = rsp;
    d_we  = 1'b0;
    r_we  = 1'b0;
    r_wd  = t;
    if (ir[15]) begin
      dsp_n = dsp + DW'(1);
      d_we  = 1'b1;
      t_n   = {1'b0, ir[14:0]};
    end else begin
      case (ir[14:13])
        2'b00: pc_n = target;
        2'b01: begin
          pc_n  = t == 16'd0 ? target : pc_inc;
          t_n   = n;
          dsp_n = dsp - DW'(1);
        end
        2'b10: begin
          rsp_n = rsp + RW'(1);
          r_we  = 1'b1;
          r_wd  = {pc_inc, 1'b0};
          pc_n  = target;
        end
        default: begin
          dsp_n = dsp + DW'($signed(ir[1:0]));
          rsp_n = rsp + RW'($signed(ir[3:2]));
          d_we  = ir[7];
          r_we  = ir[6];
          t_n   = alu;
          pc_n  = ir[12] ? r[15:1] : pc_inc;
        end
      endcase
    end
  end
  // sequencer and register commit; memory instructions commit only on data ack
  always_ff @(posedge sys_clk_i or posedge sys_res_i) begin
    if (sys_res_i) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      ir    <= '0;
      t     <= '0;
      dsp   <= '0;
      rsp   <= '0;
    end else begin
      if (commit) begin
        pc  <= pc_n;
        t   <= t_n;
        dsp <= dsp_n;
        rsp <= rsp_n;
      end
      case (state)
        BOOT:    state <= FETCH;
        FETCH:   if (ins_ack_i) begin
          ir    <= ins_dat_i;
          state <= EXEC;
        end
        EXEC:    state <= is_mem ? MEM : FETCH;
        MEM:     if (dat_ack_i) state <= FETCH;
        default: state <= BOOT;
      endcase
    end
  end
  // stack RAMs are written at the new pointer on commit and are never cleared
  always_ff @(posedge sys_clk_i) begin
    if (commit && d_we) dstack[dsp_n] <= t;
    if (commit && r_we) rstack[rsp_n] <= r_wd;
  end
endmodule

// File: tb/tb_j1b_core.sv
// tb_j1b_core: directed vector and sequence bench for j1b_core
module tb_j1b_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:1] ins_adr_o, dat_adr_o;
  logic [15:0] ins_dat_i, dat_dat_o, dat_dat_i;
  logic        ins_cyc_o, ins_stb_o, ins_ack_i;
  logic        dat_we_o, dat_cyc_o, dat_stb_o, dat_ack_i;
  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];
  int          waits = 0;
  int          dwait = 0;
  int          nvec = 0;
  int          nerr = 0;

  typedef struct packed {
    logic [15:0] p0, p1, p2, p3;
    logic [14:0] stop;
    logic [15:0] t;
    logic [7:0]  dsp;
  } vec_t;
  vec_t tbl [18];

  j1b_core dut (
    .sys_clk_i(clk), .sys_res_i(rst),
    .ins_adr_o(ins_adr_o), .ins_dat_i(ins_dat_i), .ins_cyc_o(ins_cyc_o),
    .ins_stb_o(ins_stb_o), .ins_ack_i(ins_ack_i),
    .dat_adr_o(dat_adr_o), .dat_dat_o(dat_dat_o), .dat_dat_i(dat_dat_i),
    .dat_we_o(dat_we_o), .dat_cyc_o(dat_cyc_o), .dat_stb_o(dat_stb_o),
    .dat_ack_i(dat_ack_i)
  );

  always #5 clk = ~clk;

  assign ins_dat_i = imem[ins_adr_o];
  assign ins_ack_i = ins_cyc_o & ins_stb_o;
  assign dat_dat_i = dmem[dat_adr_o];
  assign dat_ack_i = dat_cyc_o & dat_stb_o & (dwait == waits);

  always @(posedge clk) begin
    if (dat_cyc_o && dat_stb_o && !dat_ack_i) dwait <= dwait + 1;
    else dwait <= 0;
    if (dat_ack_i && dat_we_o) dmem[dat_adr_o] <= dat_dat_o;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 512; i++) imem[i] = 16'h0000;
  endtask

  task automatic run_to(input logic [15:1] adr, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (ins_cyc_o && ins_adr_o == adr) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok, both, bad;
    int sc, lc;
    tbl[0]  = '{16'h8005, 16'h8003, 16'h6203, 16'h0000, 15'd3,  16'h0008, 8'd1};
    tbl[1]  = '{16'h800C, 16'h800A, 16'h6303, 16'h0000, 15'd3,  16'h0008, 8'd1};
    tbl[2]  = '{16'h800C, 16'h800A, 16'h6403, 16'h0000, 15'd3,  16'h000E, 8'd1};
    tbl[3]  = '{16'h800C, 16'h800A, 16'h6503, 16'h0000, 15'd3,  16'h0006, 8'd1};
    tbl[4]  = '{16'h8005, 16'h6600, 16'h0000, 16'h0000, 15'd2,  16'hFFFA, 8'd1};
    tbl[5]  = '{16'h8005, 16'h8005, 16'h6703, 16'h0000, 15'd3,  16'hFFFF, 8'd1};
    tbl[6]  = '{16'h8005, 16'h8006, 16'h6703, 16'h0000, 15'd3,  16'h0000, 8'd1};
    tbl[7]  = '{16'h8003, 16'h6600, 16'h8001, 16'h6803, 15'd4,  16'hFFFF, 8'd1};
    tbl[8]  = '{16'h8003, 16'h6600, 16'h8001, 16'h6F03, 15'd4,  16'h0000, 8'd1};
    tbl[9]  = '{16'h8F00, 16'h8004, 16'h6903, 16'h0000, 15'd3,  16'h00F0, 8'd1};
    tbl[10] = '{16'h8003, 16'h8004, 16'h6D03, 16'h0000, 15'd3,  16'h0030, 8'd1};
    tbl[11] = '{16'h8005, 16'h6A00, 16'h0000, 16'h0000, 15'd2,  16'h0004, 8'd1};
    tbl[12] = '{16'h8005, 16'h8006, 16'h6081, 16'h6103, 15'd4,  16'h0006, 8'd2};
    tbl[13] = '{16'h8007, 16'h6044, 16'h8001, 16'h6B00, 15'd4,  16'h0007, 8'd2};
    tbl[14] = '{16'h8001, 16'h8002, 16'h6E00, 16'h0000, 15'd3,  16'h0002, 8'd2};
    tbl[15] = '{16'h0005, 16'h0000, 16'h0000, 16'h0000, 15'd5,  16'h0000, 8'd0};
    tbl[16] = '{16'h8000, 16'h2010, 16'h0000, 16'h0000, 15'd16, 16'h0000, 8'd0};
    tbl[17] = '{16'h8009, 16'h8007, 16'h2010, 16'h0000, 15'd3,  16'h0009, 8'd1};

    // reset values and boot timing with a zero-wait instruction slave
    clear_imem();
    imem[0] = 16'h8001; imem[1] = 16'h8002; imem[2] = 16'h8003; imem[3] = 16'h8004;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ins_cyc", 32'(ins_cyc_o), 32'd0);
    check("rst_dat_cyc", 32'({dat_cyc_o, dat_stb_o, dat_we_o}), 32'd0);
    check("rst_ins_adr", 32'(ins_adr_o), 32'h0);
    check("rst_dat_adr", 32'(dat_adr_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("boot_idle", 32'(ins_cyc_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("fetch_cyc", 32'({ins_cyc_o, ins_stb_o}), 32'd3);
      check("fetch_adr", 32'(ins_adr_o), 32'(k));
      @(posedge clk); #1;
      check("exec_idle", 32'(ins_cyc_o), 32'd0);
    end

    // single-instruction-group vectors from a fresh reset
    foreach (tbl[i]) begin
      clear_imem();
      imem[0] = tbl[i].p0; imem[1] = tbl[i].p1; imem[2] = tbl[i].p2; imem[3] = tbl[i].p3;
      waits = 0;
      do_reset();
      run_to(tbl[i].stop, 100, ok);
      check($sformatf("vec%0d_reach", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_t", i), 32'(dut.t), 32'(tbl[i].t));
      check($sformatf("vec%0d_dsp", i), 32'(dut.dsp), 32'(tbl[i].dsp));
    end

    // store then load through a two-wait-state data slave
    clear_imem();
    imem[0] = 16'h9234; imem[1] = 16'h8040; imem[2] = 16'h6023; imem[3] = 16'h8040; imem[4] = 16'h6C00;
    waits = 2;
    do_reset();
    ok = 1'b0; both = 1'b0; bad = 1'b0; sc = 0; lc = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (ins_cyc_o && dat_cyc_o) both = 1'b1;
      if (dat_cyc_o && dat_we_o) begin
        sc++;
        if (dat_adr_o !== 15'h20 || dat_dat_o !== 16'h1234 || !dat_stb_o) bad = 1'b1;
      end
      if (dat_cyc_o && !dat_we_o) lc++;
      if (ins_cyc_o && ins_adr_o == 15'd5) ok = 1'b1;
    end
    check("mem_reach", 32'(ok), 32'd1);
    check("store_cycles", 32'(sc), 32'd3);
    check("store_stable", 32'(bad), 32'd0);
    check("load_cycles", 32'(lc), 32'd3);
    check("bus_exclusive", 32'(both), 32'd0);
    check("store_mem", 32'(dmem[15'h20]), 32'h1234);
    check("load_t", 32'(dut.t), 32'h1234);
    check("load_dsp", 32'(dut.dsp), 32'd2);
    waits = 0;

    // call then return
    clear_imem();
    imem[0] = 16'h4100; imem[15'h100] = 16'h700C;
    do_reset();
    run_to(15'h100, 20, ok);
    check("call_reach", 32'(ok), 32'd1);
    check("call_rsp", 32'(dut.rsp), 32'd1);
    check("call_r", 32'(dut.r), 32'h0002);
    run_to(15'h001, 20, ok);
    check("ret_reach", 32'(ok), 32'd1);
    check("ret_rsp", 32'(dut.rsp), 32'd0);

    // data stack wrap after DSTACK_DEPTH+1 pushes
    clear_imem();
    for (int i = 0; i < 17; i++) imem[i] = 16'h8001 + 16'(i);
    imem[17] = 16'h6E00;
    do_reset();
    run_to(15'd18, 200, ok);
    check("wrap_reach", 32'(ok), 32'd1);
    check("wrap_depth_t", 32'(dut.t), 32'd1);
    check("wrap_dsp", 32'(dut.dsp), 32'd1);

    // reset asserted during a stalled load
    clear_imem();
    imem[0] = 16'h8040; imem[1] = 16'h6C00;
    waits = 1000;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      if (dat_cyc_o) ok = 1'b1;
    end
    check("midrst_mem_reach", 32'(ok), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_dat_cyc", 32'({dat_cyc_o, dat_stb_o, dat_we_o}), 32'd0);
    check("midrst_t", 32'(dut.t), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_refetch_cyc", 32'(ins_cyc_o), 32'd1);
    check("midrst_refetch_adr", 32'(ins_adr_o), 32'h0);
    waits = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
